// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: register address/data widths, arbiter state
// encoding, and the non-zero address-match helper used for hazard detection.
package riscv_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef logic [XLEN-1:0]   xdata_t;
    typedef logic [REG_AW-1:0] xaddr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } arb_state_e;

    // x0 never participates in a dependency.
    function automatic logic addr_hit(input xaddr_t a, input xaddr_t b);
        return (a != '0) && (a == b);
    endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker. The pointer moves past the winner each
// time the caller reports that the pick was actually granted.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    input  logic adv_i,
    output logic pick0_o,
    output logic pick1_o
);
    // ptr_q == 0: wb0 has priority on a tie, ptr_q == 1: wb1 has priority.
    logic ptr_q;
    logic ptr_d;

    assign pick0_o = req0_i && (!req1_i || !ptr_q);
    assign pick1_o = req1_i && (!req0_i || ptr_q);
    assign ptr_d   = adv_i ? pick0_o : ptr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/regfile_port_arbiter.sv
// Single-port register-file arbiter: one decode read vs. two writebacks, with
// write-starvation guard. Define REGFILE_ARB_BYPASS_EN to forward pending writes.
module regfile_port_arbiter
    import riscv_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [REG_AW-1:0] rd_rs1_addr,
    input  logic [REG_AW-1:0] rd_rs2_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [XLEN-1:0]   rd_rs1_data,
    output logic [XLEN-1:0]   rd_rs2_data,
    input  logic              wb0_req,
    input  logic [REG_AW-1:0] wb0_addr,
    input  logic [XLEN-1:0]   wb0_data,
    output logic              wb0_gnt,
    input  logic              wb1_req,
    input  logic [REG_AW-1:0] wb1_addr,
    input  logic [XLEN-1:0]   wb1_data,
    output logic              wb1_gnt,
    output logic              rf_read_en,
    output logic              rf_write_en,
    output logic [REG_AW-1:0] rf_rs1_addr,
    output logic [REG_AW-1:0] rf_rs2_addr,
    output logic [REG_AW-1:0] rf_write_addr,
    output logic [XLEN-1:0]   rf_write_data,
    input  logic [XLEN-1:0]   rf_rs1_data,
    input  logic [XLEN-1:0]   rf_rs2_data
);
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_e       state_q;
    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             rd_valid_q;
    xdata_t           rs1_q;
    xdata_t           rs2_q;
    xdata_t           rs1_d;
    xdata_t           rs2_d;
    xdata_t           src1_val;
    xdata_t           src2_val;

    logic wr_pend;
    logic starve_hit;
    logic hazard;
    logic rd_gnt_w;
    logic wr_gnt_w;
    logic pick0;
    logic pick1;

    assign wr_pend    = wb0_req || wb1_req;
    assign starve_hit = wr_pend && (starve_q == CNT_MAX);

`ifdef REGFILE_ARB_BYPASS_EN
    assign hazard = 1'b0;

    // wb1 is checked last so it wins when both writers target the same source.
    always_comb begin
        src1_val = rf_rs1_data;
        src2_val = rf_rs2_data;
        if (wb0_req && addr_hit(wb0_addr, rd_rs1_addr)) src1_val = wb0_data;
        if (wb1_req && addr_hit(wb1_addr, rd_rs1_addr)) src1_val = wb1_data;
        if (wb0_req && addr_hit(wb0_addr, rd_rs2_addr)) src2_val = wb0_data;
        if (wb1_req && addr_hit(wb1_addr, rd_rs2_addr)) src2_val = wb1_data;
    end
`else
    // Without forwarding, a read must wait until every conflicting write has landed.
    assign hazard = (wb0_req && (addr_hit(wb0_addr, rd_rs1_addr) || addr_hit(wb0_addr, rd_rs2_addr)))
                 || (wb1_req && (addr_hit(wb1_addr, rd_rs1_addr) || addr_hit(wb1_addr, rd_rs2_addr)));
    assign src1_val = rf_rs1_data;
    assign src2_val = rf_rs2_data;
`endif

    assign rs1_d = (rd_rs1_addr == '0) ? '0 : src1_val;
    assign rs2_d = (rd_rs2_addr == '0) ? '0 : src2_val;

    // Grants are gated by rst so they drop the instant reset asserts.
    assign rd_gnt_w = rst && rd_req && !starve_hit && !hazard;
    assign wr_gnt_w = rst && wr_pend && !rd_gnt_w;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req0_i  (wb0_req),
        .req1_i  (wb1_req),
        .adv_i   (wr_gnt_w),
        .pick0_o (pick0),
        .pick1_o (pick1)
    );

    assign rd_gnt        = rd_gnt_w;
    assign wb0_gnt       = wr_gnt_w && pick0;
    assign wb1_gnt       = wr_gnt_w && pick1;
    assign rf_read_en    = rd_gnt_w;
    assign rf_rs1_addr   = rd_gnt_w ? rd_rs1_addr : '0;
    assign rf_rs2_addr   = rd_gnt_w ? rd_rs2_addr : '0;
    assign rf_write_addr = wb0_gnt ? wb0_addr : (wb1_gnt ? wb1_addr : '0);
    assign rf_write_data = wb0_gnt ? wb0_data : (wb1_gnt ? wb1_data : '0);
    assign rf_write_en   = wr_gnt_w && (rf_write_addr != '0);

    assign rd_valid    = rd_valid_q;
    assign rd_rs1_data = rs1_q;
    assign rd_rs2_data = rs2_q;

    always_comb begin
        starve_d = starve_q;
        if (!wr_pend || wr_gnt_w) begin
            starve_d = '0;
        end else if (starve_q != CNT_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            rd_valid_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else begin
            starve_q   <= starve_d;
            rd_valid_q <= rd_gnt_w;
            if (rd_gnt_w) begin
                rs1_q <= rs1_d;
                rs2_q <= rs2_d;
            end
            // State records the operation issued this cycle.
            unique case (state_q)
                ST_IDLE: state_q <= rd_gnt_w ? ST_RD : (wr_gnt_w ? ST_WR : ST_IDLE);
                ST_RD:   state_q <= rd_gnt_w ? ST_RD : (wr_gnt_w ? ST_WR : ST_IDLE);
                ST_WR:   state_q <= wr_gnt_w ? ST_WR : (rd_gnt_w ? ST_RD : ST_IDLE);
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural register file
// (combinational read, x0 reads as all-ones so zeroing is observable).
module tb_regfile_port_arbiter;
    logic        clk;
    logic        rst;
    logic        rd_req;
    logic [4:0]  rd_rs1_addr;
    logic [4:0]  rd_rs2_addr;
    logic        rd_gnt;
    logic        rd_valid;
    logic [31:0] rd_rs1_data;
    logic [31:0] rd_rs2_data;
    logic        wb0_req;
    logic [4:0]  wb0_addr;
    logic [31:0] wb0_data;
    logic        wb0_gnt;
    logic        wb1_req;
    logic [4:0]  wb1_addr;
    logic [31:0] wb1_data;
    logic        wb1_gnt;
    logic        rf_read_en;
    logic        rf_write_en;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic [31:0] rf_rs1_data;
    logic [31:0] rf_rs2_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rf_mem [32];
    logic [4:0]  ctl;

    assign ctl = {rd_gnt, wb0_gnt, wb1_gnt, rf_read_en, rf_write_en};

    regfile_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_req        (rd_req),
        .rd_rs1_addr   (rd_rs1_addr),
        .rd_rs2_addr   (rd_rs2_addr),
        .rd_gnt        (rd_gnt),
        .rd_valid      (rd_valid),
        .rd_rs1_data   (rd_rs1_data),
        .rd_rs2_data   (rd_rs2_data),
        .wb0_req       (wb0_req),
        .wb0_addr      (wb0_addr),
        .wb0_data      (wb0_data),
        .wb0_gnt       (wb0_gnt),
        .wb1_req       (wb1_req),
        .wb1_addr      (wb1_addr),
        .wb1_data      (wb1_data),
        .wb1_gnt       (wb1_gnt),
        .rf_read_en    (rf_read_en),
        .rf_write_en   (rf_write_en),
        .rf_rs1_addr   (rf_rs1_addr),
        .rf_rs2_addr   (rf_rs2_addr),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .rf_rs1_data   (rf_rs1_data),
        .rf_rs2_data   (rf_rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rf_rs1_data = (rf_rs1_addr == 5'd0) ? 32'hFFFF_FFFF : rf_mem[rf_rs1_addr];
        rf_rs2_data = (rf_rs2_addr == 5'd0) ? 32'hFFFF_FFFF : rf_mem[rf_rs2_addr];
    end

    always @(posedge clk) begin
        if (rf_write_en) rf_mem[rf_write_addr] <= rf_write_data;
    end

    task automatic clear_inputs();
        rd_req = 1'b0; rd_rs1_addr = '0; rd_rs2_addr = '0;
        wb0_req = 1'b0; wb0_addr = '0; wb0_data = '0;
        wb1_req = 1'b0; wb1_addr = '0; wb1_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        rd_req = 1'b1; rd_rs1_addr = 5'd3; wb0_req = 1'b1; wb0_addr = 5'd4; wb1_req = 1'b1; wb1_addr = 5'd6;
        step();
        @(negedge clk);
        n_checks++;
        if (ctl !== 5'b00000) begin n_errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 5'b00000); end
        n_checks++;
        if ({rd_valid, rd_rs1_data, rd_rs2_data} !== 65'd0) begin
            n_errors++; $display("FAIL reset_rd: got valid=%b rs1=%h rs2=%h expected all 0", rd_valid, rd_rs1_data, rd_rs2_data);
        end
        n_checks++;
        if ({rf_rs1_addr, rf_write_addr, rf_write_data} !== 42'd0) begin
            n_errors++; $display("FAIL reset_rf: got rs1a=%0d wa=%0d wd=%h expected 0", rf_rs1_addr, rf_write_addr, rf_write_data);
        end
        $display("[test_reset] ctl=%b rd_valid=%b", ctl, rd_valid);
        step();
    endtask

    task automatic test_write_then_read();
        do_reset();
        wb0_req = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (ctl !== 5'b01001) begin n_errors++; $display("FAIL wr_x5_ctl: got %b expected %b", ctl, 5'b01001); end
        n_checks++;
        if ({rf_write_addr, rf_write_data} !== {5'd5, 32'hDEAD_BEEF}) begin
            n_errors++; $display("FAIL wr_x5_bus: got addr=%0d data=%h expected addr=5 data=deadbeef", rf_write_addr, rf_write_data);
        end
        $display("[test_write_then_read] write x5 ctl=%b", ctl);
        step();
        wb0_req = 1'b0;
        rd_req = 1'b1; rd_rs1_addr = 5'd5; rd_rs2_addr = 5'd0;
        @(negedge clk);
        n_checks++;
        if ({ctl, rd_valid} !== 6'b100100) begin n_errors++; $display("FAIL rd_x5_gnt: got ctl,valid=%b expected %b", {ctl, rd_valid}, 6'b100100); end
        step();
        rd_req = 1'b0;
        n_checks++;
        if ({rd_valid, rd_rs1_data, rd_rs2_data} !== {1'b1, 32'hDEAD_BEEF, 32'h0}) begin
            n_errors++; $display("FAIL rd_x5_resp: got valid=%b rs1=%h rs2=%h expected 1 deadbeef 0", rd_valid, rd_rs1_data, rd_rs2_data);
        end
        $display("[test_write_then_read] read x5 valid=%b rs1=%h rs2=%h", rd_valid, rd_rs1_data, rd_rs2_data);
        step();
        n_checks++;
        if ({rd_valid, rd_rs1_data} !== {1'b0, 32'hDEAD_BEEF}) begin
            n_errors++; $display("FAIL rd_x5_hold: got valid=%b rs1=%h expected 0 deadbeef", rd_valid, rd_rs1_data);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        wb0_req = 1'b1; wb0_addr = 5'd10; wb0_data = 32'h0000_000A;
        wb1_req = 1'b1; wb1_addr = 5'd11; wb1_data = 32'h0000_000B;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({wb0_gnt, wb1_gnt, rf_write_addr} !== ((i % 2 == 0) ? {2'b10, 5'd10} : {2'b01, 5'd11})) begin
                n_errors++;
                $display("FAIL rr_cycle%0d: got gnt=%b%b addr=%0d expected %s", i, wb0_gnt, wb1_gnt, rf_write_addr,
                         (i % 2 == 0) ? "wb0 addr 10" : "wb1 addr 11");
            end
            $display("[test_round_robin] cycle %0d wb0_gnt=%b wb1_gnt=%b addr=%0d", i, wb0_gnt, wb1_gnt, rf_write_addr);
            step();
        end
        clear_inputs();
    endtask

    task automatic test_starvation();
        do_reset();
        rd_req = 1'b1; rd_rs1_addr = 5'd1; rd_rs2_addr = 5'd2;
        wb0_req = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h0000_0099;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (ctl !== ((c < 5) ? 5'b10010 : 5'b01001)) begin
                n_errors++; $display("FAIL starve_cycle%0d: got %b expected %b", c, ctl, (c < 5) ? 5'b10010 : 5'b01001);
            end
            $display("[test_starvation] cycle %0d ctl=%b", c, ctl);
            step();
        end
        wb0_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ctl, rd_valid} !== 6'b100100) begin n_errors++; $display("FAIL starve_after: got ctl,valid=%b expected %b", {ctl, rd_valid}, 6'b100100); end
        step();
        rd_req = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL starve_resume_valid: got %b expected 1", rd_valid); end
        step();
    endtask

    task automatic test_x0_write();
        do_reset();
        wb1_req = 1'b1; wb1_addr = 5'd0; wb1_data = 32'h0000_1234;
        @(negedge clk);
        n_checks++;
        if (ctl !== 5'b00100) begin n_errors++; $display("FAIL x0_wr_ctl: got %b expected %b", ctl, 5'b00100); end
        $display("[test_x0_write] write x0 ctl=%b", ctl);
        step();
        wb1_req = 1'b0;
        rd_req = 1'b1; rd_rs1_addr = 5'd0; rd_rs2_addr = 5'd0;
        @(negedge clk);
        n_checks++;
        if (ctl !== 5'b10010) begin n_errors++; $display("FAIL x0_rd_ctl: got %b expected %b", ctl, 5'b10010); end
        step();
        rd_req = 1'b0;
        n_checks++;
        if ({rd_valid, rd_rs1_data, rd_rs2_data} !== {1'b1, 64'd0}) begin
            n_errors++; $display("FAIL x0_rd_resp: got valid=%b rs1=%h rs2=%h expected 1 0 0", rd_valid, rd_rs1_data, rd_rs2_data);
        end
        $display("[test_x0_write] read x0 rs1=%h", rd_rs1_data);
    endtask

    task automatic test_hazard();
        do_reset();
        wb1_req = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h1111_1111;
        @(negedge clk);
        n_checks++;
        if (ctl !== 5'b00101) begin n_errors++; $display("FAIL hz_pre_ctl: got %b expected %b", ctl, 5'b00101); end
        step();
        wb1_req = 1'b0;
        wb0_req = 1'b1; wb0_addr = 5'd7; wb0_data = 32'hA5A5_A5A5;
        rd_req = 1'b1; rd_rs1_addr = 5'd7; rd_rs2_addr = 5'd0;
`ifdef REGFILE_ARB_BYPASS_EN
        @(negedge clk);
        n_checks++;
        if (ctl !== 5'b10010) begin n_errors++; $display("FAIL hz_byp_ctl: got %b expected %b", ctl, 5'b10010); end
        step();
        rd_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl !== 5'b01001) begin n_errors++; $display("FAIL hz_byp_wr: got %b expected %b", ctl, 5'b01001); end
        step();
        wb0_req = 1'b0;
        n_checks++;
        if (rd_rs1_data !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL hz_byp_data: got %h expected a5a5a5a5", rd_rs1_data); end
`else
        @(negedge clk);
        n_checks++;
        if (ctl !== 5'b01001) begin n_errors++; $display("FAIL hz_wr_first: got %b expected %b", ctl, 5'b01001); end
        step();
        wb0_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl !== 5'b10010) begin n_errors++; $display("FAIL hz_rd_next: got %b expected %b", ctl, 5'b10010); end
        step();
        rd_req = 1'b0;
        n_checks++;
        if ({rd_valid, rd_rs1_data, rd_rs2_data} !== {1'b1, 32'hA5A5_A5A5, 32'h0}) begin
            n_errors++; $display("FAIL hz_rd_data: got valid=%b rs1=%h rs2=%h expected 1 a5a5a5a5 0", rd_valid, rd_rs1_data, rd_rs2_data);
        end
`endif
        $display("[test_hazard] rs1=%h", rd_rs1_data);
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        rd_req = 1'b1; rd_rs1_addr = 5'd5; rd_rs2_addr = 5'd0;
        wb0_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl !== 5'b10010) begin n_errors++; $display("FAIL rst_mid_pre: got %b expected %b", ctl, 5'b10010); end
        step();
        n_checks++;
        if ({rd_valid, rd_rs1_data} !== {1'b1, 32'hDEAD_BEEF}) begin
            n_errors++; $display("FAIL rst_mid_first: got valid=%b rs1=%h expected 1 deadbeef", rd_valid, rd_rs1_data);
        end
        wb0_req = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h0000_0033;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({ctl, rd_valid, rd_rs1_data, rf_rs1_addr, rf_write_data} !== 75'd0) begin
            n_errors++; $display("FAIL rst_mid_async: got ctl=%b valid=%b rs1=%h rs1a=%0d wd=%h expected all 0",
                                 ctl, rd_valid, rd_rs1_data, rf_rs1_addr, rf_write_data);
        end
        step();
        n_checks++;
        if ({ctl, rd_valid} !== 6'd0) begin n_errors++; $display("FAIL rst_mid_hold: got ctl,valid=%b expected 0", {ctl, rd_valid}); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl !== 5'b10010) begin n_errors++; $display("FAIL rst_mid_release: got %b expected %b", ctl, 5'b10010); end
        step();
        clear_inputs();
        n_checks++;
        if ({rd_valid, rd_rs1_data} !== {1'b1, 32'hDEAD_BEEF}) begin
            n_errors++; $display("FAIL rst_mid_after: got valid=%b rs1=%h expected 1 deadbeef", rd_valid, rd_rs1_data);
        end
        $display("[test_reset_mid_read] after release valid=%b rs1=%h", rd_valid, rd_rs1_data);
        step();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_write_then_read();
        test_round_robin();
        test_starvation();
        test_x0_write();
        test_hazard();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/regfile_port_arbiter.md
REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive cycles a pending write may lose to a read before it is forced.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports rd_req in 1, rd_rs1_addr in 5, rd_rs2_addr in 5, rd_gnt out 1: decode read request, its two source addresses, and the same-cycle grant.
REQ-005 SHALL have ports rd_valid out 1, rd_rs1_data out 32, rd_rs2_data out 32: registered read response.
REQ-006 SHALL have ports wb0_req in 1, wb0_addr in 5, wb0_data in 32, wb0_gnt out 1: ALU writeback requester.
REQ-007 SHALL have ports wb1_req in 1, wb1_addr in 5, wb1_data in 32, wb1_gnt out 1: load writeback requester.
REQ-008 SHALL have ports rf_read_en, rf_write_en out 1; rf_rs1_addr, rf_rs2_addr, rf_write_addr out 5; rf_write_data out 32; rf_rs1_data, rf_rs2_data in 32: register-file side.

Function
REQ-009 SHALL issue at most one operation per cycle; rf_read_en and rf_write_en SHALL never be high together.
REQ-010 SHALL drive grants and rf_* controls combinationally from current requests and state; requesters hold req/addr/data until granted.
REQ-011 SHALL grant the read over any write unless starve_cnt == STARVE_MAX, in which case a pending write is granted and rd_gnt stays low.
REQ-012 SHALL increment starve_cnt (saturating at STARVE_MAX) each cycle a write is pending but not granted, and clear it on any write grant or when no write is pending.
REQ-013 SHALL arbitrate wb0/wb1 round-robin; rr pointer flips to the other requester after each write grant; a lone requester always wins.
REQ-014 SHALL grant writes with address 0 but keep rf_write_en low (x0 discarded).
REQ-015 SHALL assert rd_valid exactly one cycle after rd_gnt with rd_rs1_data/rd_rs2_data taken from rf_rs1_data/rf_rs2_data; rd_valid low otherwise; data held between responses.
REQ-016 SHALL return 0 for any source address 0 regardless of register-file data.
REQ-017 SHALL track state IDLE/RD/WR (last issued operation); IDLE->RD on read grant, IDLE/RD/WR->WR on write grant, any->IDLE when nothing granted.

Reset
REQ-018 SHALL, while rst is low, force all grants, rf_read_en, rf_write_en, rd_valid low, rd_*_data to 0, state IDLE, starve_cnt 0, rr pointer to wb0.
REQ-019 SHALL suppress rd_valid for a read granted in the cycle rst asserts; first grant possible the cycle after rst deasserts.

Configuration
REQ-020 SHALL, with REGFILE_ARB_BYPASS_EN defined, forward pending (ungranted) write data into a granted read whose non-zero source address matches wb0_addr/wb1_addr, wb1 winning if both match, delivered with rd_valid per REQ-015.
REQ-021 SHALL, without REGFILE_ARB_BYPASS_EN, hold rd_gnt low while any pending write targets a non-zero rd_rs1_addr or rd_rs2_addr, granting those writes first.

Structure
REQ-022 SHALL take address width (5), data width (32) and state encoding IDLE/RD/WR from the shared riscv package.
REQ-023 SHALL instantiate one sub-module rr_arbiter2 (two-requester round-robin with pointer register); all else inline.

Verification
REQ-024 Bench SHALL cover: wb0 writes 0xDEADBEEF to x5, then read rs1=5 rs2=0 -> rd_valid one cycle after rd_gnt, rs1=0xDEADBEEF, rs2=0.
REQ-025 Bench SHALL cover: wb0 and wb1 both requesting for 4 cycles, no read -> grants alternate wb0,wb1,wb0,wb1.
REQ-026 Bench SHALL cover: rd_req held high with wb0_req high (no address match) -> rd_gnt for 4 cycles, wb0_gnt on cycle 5 with rd_gnt low.
REQ-027 Bench SHALL cover: wb1 write 0x1234 to x0, then read x0 -> rf_write_en stays low, rs1 data 0.
REQ-028 Bench SHALL cover: read rs1=7 while wb0 pending 0xA5A5A5A5 to x7 -> with macro rd_gnt immediate, rs1=0xA5A5A5A5; without macro wb0_gnt first, read granted next cycle, same data.
REQ-029 Bench SHALL cover: rst low in the cycle of a read grant -> no rd_valid, all outputs 0 until rst high.
